// File: rtl/mini_alu_sequencer.sv
// Operand-entry sequencer for the mini ALU.
// ENTER latches A, then B, then op. The ALU inputs are then held stable for a
// settle window, the result is captured, and it is shown until the next ENTER.
// CLEAR returns to A entry from any state.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  GET_A   | show switches[9:6]; ENTER latches operand A
//  GET_B   | show switches[5:2]; ENTER latches operand B
//  GET_OP  | show switches[1];   ENTER latches op and starts settling
//  EXEC    | ALU inputs frozen, count SETTLE_CYCLES, then capture result
//  SHOW    | captured result displayed; ENTER returns to GET_A
module mini_alu_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int BLINK_DIV     = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enter_btn,
    input  logic        clear_btn,
    input  logic [9:0]  switches,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic        alu_op,
    input  logic [19:0] alu_result,
    output logic [19:0] disp_value,
    output logic        disp_blank,
    output logic [2:0]  stage,
    output logic        result_valid
);

    localparam logic [2:0] S_GET_A  = 3'd0;
    localparam logic [2:0] S_GET_B  = 3'd1;
    localparam logic [2:0] S_GET_OP = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_SHOW   = 3'd4;

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);

    // [0],[1] are the synchronizer pair, [2] holds the previous synced level
    logic [2:0]    enter_sync_q;
    logic [2:0]    clear_sync_q;
    logic          enter_p;
    logic          clear_p;

    logic [2:0]    state_q, state_d;
    logic [3:0]    alu_a_q, alu_a_d;
    logic [3:0]    alu_b_q, alu_b_d;
    logic          alu_op_q, alu_op_d;
    logic [19:0]   disp_value_q, disp_value_d;
    logic          disp_blank_q, disp_blank_d;
    logic          result_valid_q, result_valid_d;
    logic [CW-1:0] settle_q, settle_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          in_entry;

    // switches[0] has no function in this block
    logic unused_sw0;
    assign unused_sw0 = switches[0];

    assign enter_p = enter_sync_q[1] & ~enter_sync_q[2];
    assign clear_p = clear_sync_q[1] & ~clear_sync_q[2];
    assign in_entry = (state_q == S_GET_A) || (state_q == S_GET_B) || (state_q == S_GET_OP);

    // Main sequencing: operand latches, settle counter and result capture
    always_comb begin
        state_d        = state_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        disp_value_d   = disp_value_q;
        result_valid_d = result_valid_q;
        settle_d       = settle_q;
        if (clear_p) begin
            state_d        = S_GET_A;
            alu_a_d        = 4'd0;
            alu_b_d        = 4'd0;
            alu_op_d       = 1'b0;
            disp_value_d   = 20'd0;
            result_valid_d = 1'b0;
            settle_d       = '0;
        end else begin
            case (state_q)
                S_GET_A: begin
                    if (enter_p) begin
                        alu_a_d = switches[9:6];
                        state_d = S_GET_B;
                    end
                end
                S_GET_B: begin
                    if (enter_p) begin
                        alu_b_d = switches[5:2];
                        state_d = S_GET_OP;
                    end
                end
                S_GET_OP: begin
                    if (enter_p) begin
                        alu_op_d = switches[1];
                        settle_d = '0;
                        state_d  = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (settle_q == SETTLE_LAST) begin
                        disp_value_d   = alu_result;
                        result_valid_d = 1'b1;
                        state_d        = S_SHOW;
                    end else begin
                        settle_d = settle_q + CW'(1);
                    end
                end
                S_SHOW: begin
                    if (enter_p) begin
                        result_valid_d = 1'b0;
                        state_d        = S_GET_A;
                    end
                end
                default: state_d = S_GET_A;
            endcase
            // entry stages show the switch field belonging to the stage being entered
            case (state_d)
                S_GET_A:  disp_value_d = {16'd0, switches[9:6]};
                S_GET_B:  disp_value_d = {16'd0, switches[5:2]};
                S_GET_OP: disp_value_d = {19'd0, switches[1]};
                default:  ;
            endcase
        end
    end

    // Prompt blink: restarts unblanked on every state change, idle outside entry
    always_comb begin
        blink_d      = blink_q + BW'(1);
        disp_blank_d = disp_blank_q;
        if (clear_p || (state_d != state_q) || !in_entry) begin
            blink_d      = '0;
            disp_blank_d = 1'b0;
        end else if (blink_q == BLINK_LAST) begin
            blink_d      = '0;
            disp_blank_d = ~disp_blank_q;
        end
    end

    // LED stage indicator decoded from the current state
    always_comb begin
        case (state_q)
            S_GET_A:  stage = 3'b001;
            S_GET_B:  stage = 3'b010;
            S_GET_OP: stage = 3'b100;
            default:  stage = 3'b000;
        endcase
    end

    // All state registers, including the button synchronizers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_sync_q   <= 3'b000;
            clear_sync_q   <= 3'b000;
            state_q        <= S_GET_A;
            alu_a_q        <= 4'd0;
            alu_b_q        <= 4'd0;
            alu_op_q       <= 1'b0;
            disp_value_q   <= 20'd0;
            disp_blank_q   <= 1'b0;
            result_valid_q <= 1'b0;
            settle_q       <= '0;
            blink_q        <= '0;
        end else begin
            enter_sync_q   <= {enter_sync_q[1:0], enter_btn};
            clear_sync_q   <= {clear_sync_q[1:0], clear_btn};
            state_q        <= state_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            disp_value_q   <= disp_value_d;
            disp_blank_q   <= disp_blank_d;
            result_valid_q <= result_valid_d;
            settle_q       <= settle_d;
            blink_q        <= blink_d;
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign disp_value   = disp_value_q;
    assign disp_blank   = disp_blank_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mini_alu_sequencer.sv
// Directed bench for mini_alu_sequencer with a behavioural mini ALU
// (op=0: A+B, op=1: A*B).
module tb_mini_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enter_btn;
    logic        clear_btn;
    logic [9:0]  switches;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic        alu_op;
    logic [19:0] alu_result;
    logic [19:0] disp_value;
    logic        disp_blank;
    logic [2:0]  stage;
    logic        result_valid;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (alu_op) alu_result = 20'(alu_a) * 20'(alu_b);
        else        alu_result = 20'(alu_a) + 20'(alu_b);
    end

    mini_alu_sequencer #(.SETTLE_CYCLES(4), .BLINK_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n), .enter_btn(enter_btn), .clear_btn(clear_btn),
        .switches(switches), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .disp_value(disp_value), .disp_blank(disp_blank),
        .stage(stage), .result_valid(result_valid)
    );

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise buttons at a falling edge; the action lands on the third rising
    // edge. Returns 1 time unit after that edge with the buttons still held.
    task automatic press(input logic e, input logic c);
        @(negedge clk);
        enter_btn = e;
        clear_btn = c;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_btns();
        @(negedge clk);
        enter_btn = 1'b0;
        clear_btn = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        enter_btn = 1'b0;
        clear_btn = 1'b0;
        switches  = 10'b0101_0011_1_0;
        repeat (3) @(negedge clk);
        chk("rst_alu_a", 20'(alu_a), 20'd0);
        chk("rst_alu_b", 20'(alu_b), 20'd0);
        chk("rst_alu_op", 20'(alu_op), 20'd0);
        chk("rst_disp", disp_value, 20'd0);
        chk("rst_blank", 20'(disp_blank), 20'd0);
        chk("rst_stage", 20'(stage), 20'b001);
        chk("rst_rv", 20'(result_valid), 20'd0);
        rst_n = 1'b1;

        // blink with period 8 in GET_A, starting unblanked
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            chk("blink", 20'(disp_blank), 20'((k / 8) % 2));
            if (k == 1) chk("disp_a_track", disp_value, 20'd5);
        end

        // A=5, B=3, op=1 -> 15
        press(1'b1, 1'b0);
        chk("stage_b", 20'(stage), 20'b010);
        chk("latch_a", 20'(alu_a), 20'd5);
        release_btns();
        press(1'b1, 1'b0);
        chk("stage_op", 20'(stage), 20'b100);
        chk("latch_b", 20'(alu_b), 20'd3);
        release_btns();
        press(1'b1, 1'b0);
        chk("stage_exec", 20'(stage), 20'b000);
        chk("latch_op", 20'(alu_op), 20'd1);
        chk("exec_rv0", 20'(result_valid), 20'd0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk("settle_rv", 20'(result_valid), 20'(k == 4));
            chk("exec_blank", 20'(disp_blank), 20'd0);
        end
        release_btns();
        chk("result_mul", disp_value, 20'd15);
        chk("show_stage", 20'(stage), 20'b000);
        chk("show_blank", 20'(disp_blank), 20'd0);

        // switches ignored in SHOW
        switches = 10'b1010_1100_0_1;
        repeat (3) @(negedge clk);
        chk("show_hold", disp_value, 20'd15);
        chk("show_rv", 20'(result_valid), 20'd1);
        press(1'b1, 1'b0);
        chk("back_stage", 20'(stage), 20'b001);
        chk("back_rv", 20'(result_valid), 20'd0);
        chk("keep_a", 20'(alu_a), 20'd5);
        chk("keep_op", 20'(alu_op), 20'd1);
        @(posedge clk);
        #1;
        chk("back_disp", disp_value, 20'd10);
        release_btns();

        // held ENTER gives exactly one step
        switches = 10'b1001_0110_0_0;
        @(negedge clk);
        enter_btn = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("hold_stage", 20'(stage), 20'b010);
        chk("hold_a", 20'(alu_a), 20'd9);
        release_btns();

        // ENTER and CLEAR together in GET_B: clear wins
        press(1'b1, 1'b1);
        chk("clr_stage", 20'(stage), 20'b001);
        chk("clr_a", 20'(alu_a), 20'd0);
        chk("clr_b", 20'(alu_b), 20'd0);
        chk("clr_op", 20'(alu_op), 20'd0);
        chk("clr_disp", disp_value, 20'd0);
        @(posedge clk);
        #1;
        chk("clr_track", disp_value, 20'd9);
        release_btns();

        // async reset in the middle of EXEC
        press(1'b1, 1'b0);
        release_btns();
        press(1'b1, 1'b0);
        release_btns();
        press(1'b1, 1'b0);
        chk("abort_exec", 20'(stage), 20'b000);
        @(negedge clk);
        enter_btn = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_a", 20'(alu_a), 20'd0);
        chk("abort_b", 20'(alu_b), 20'd0);
        chk("abort_disp", disp_value, 20'd0);
        chk("abort_stage", 20'(stage), 20'b001);
        chk("abort_rv", 20'(result_valid), 20'd0);
        chk("abort_blank", 20'(disp_blank), 20'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("abort_no_rv", 20'(result_valid), 20'd0);
        end

        // A=7, B=12, op=0 -> 19
        switches = 10'b0111_1100_0_0;
        press(1'b1, 1'b0);
        chk("add_latch_a", 20'(alu_a), 20'd7);
        @(posedge clk);
        #1;
        chk("disp_b_track", disp_value, 20'd12);
        release_btns();
        press(1'b1, 1'b0);
        chk("add_latch_b", 20'(alu_b), 20'd12);
        @(posedge clk);
        #1;
        chk("disp_op_track", disp_value, 20'd0);
        release_btns();
        press(1'b1, 1'b0);
        chk("add_op", 20'(alu_op), 20'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("add_rv", 20'(result_valid), 20'd1);
        chk("result_add", disp_value, 20'd19);
        release_btns();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mini_alu_sequencer.md
Name: mini_alu_sequencer

Overview:
- Sequences the combinational mini ALU (4-bit A, 4-bit B, 1-bit op, 20-bit result) from a single ENTER button.
- The user enters A, then B, then op on the switches, one ENTER press each. The block latches each value, holds ALU inputs stable for a settle window, captures the result and presents it to the seven-segment driver.
- Sits between board switches/buttons and the mini ALU/display in the top level.

Parameters:
- SETTLE_CYCLES, 4: cycles ALU inputs are held stable before the result is captured (min 1).
- BLINK_DIV, 25000000: half-period, in clk cycles, of the entry-prompt blink.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enter_btn  input  1  raw ENTER button, active-high, asynchronous to clk.
- clear_btn  input  1  raw CLEAR button, active-high, asynchronous to clk.
- switches  input  10  board switches; A = [9:6], B = [5:2], op = [1].
- alu_a  output  4  registered operand A to ALU.
- alu_b  output  4  registered operand B to ALU.
- alu_op  output  1  registered op select to ALU.
- alu_result  input  20  combinational ALU result.
- disp_value  output  20  value for the display driver.
- disp_blank  output  1  1 = display driver blanks all digits.
- stage  output  3  one-hot entry stage for LEDs: [0]=A, [1]=B, [2]=op; 000 otherwise.
- result_valid  output  1  high while a captured result is shown.

Behaviour:
- Reset (rst_n low, async): state=GET_A; alu_a=0, alu_b=0, alu_op=0; disp_value=0; disp_blank=0; stage=001; result_valid=0; blink counter=0; settle counter=0; synchronizer flops=0.
- Inputs: enter_btn and clear_btn each pass through a 2-flop synchronizer, then a rising-edge detector. This gives a 1-cycle pulse (enter_p, clear_p), 3 cycles after the raw edge. A held button produces exactly one pulse. No debounce; debounce is upstream.
- FSM states: GET_A, GET_B, GET_OP, EXEC, SHOW.
- GET_A: disp_value = {16'd0, switches[9:6]}. On enter_p, alu_a <= switches[9:6] and go to GET_B.
- GET_B: disp_value = {16'd0, switches[5:2]}. On enter_p, alu_b <= switches[5:2] and go to GET_OP.
- GET_OP: disp_value = {19'd0, switches[1]}. On enter_p, alu_op <= switches[1], settle counter <= 0, and go to EXEC.
- EXEC:
  - Settle counter increments each cycle; enter_p is ignored.
  - When the counter equals SETTLE_CYCLES-1: disp_value <= alu_result, result_valid <= 1, go to SHOW.
  - EXEC therefore lasts exactly SETTLE_CYCLES cycles.
  - stage=000 and disp_blank=0 throughout.
- SHOW:
  - disp_value holds the captured result; switch changes have no effect.
  - On enter_p: result_valid <= 0, go to GET_A. alu_a, alu_b and alu_op keep their old values until re-latched.
- Blink: in GET_A, GET_B and GET_OP, a free-running counter toggles disp_blank every BLINK_DIV cycles. The counter and disp_blank are forced to 0 on entry to EXEC, and disp_blank stays 0 in EXEC and SHOW. The counter resets to 0 on every state transition, so each entry stage starts unblanked.
- clear_p: from any state, go to GET_A next cycle. alu_a, alu_b, alu_op, disp_value, result_valid and the counters are zeroed (same as reset except the synchronizers).
- Simultaneous enter_p and clear_p: clear wins.
- Reset mid-EXEC: async clear to reset values; a partial result is never shown.
- alu_a, alu_b and alu_op change only on their latch events or on clear/reset, so the ALU inputs are glitch-free during EXEC.
- disp_value is registered in every state. In entry states it follows switches with 1-cycle latency.

Test Plan:
- Reset, then switches=10'b0101_0011_1_0, pulse enter 3 times (gap ≥5 cycles) -> alu_a=5, alu_b=3, alu_op=1. result_valid rises exactly SETTLE_CYCLES cycles after the third enter_p. disp_value equals the model ALU result for (5,3,op1).
- In SHOW, toggle all switches -> disp_value unchanged. Pulse enter -> stage=001, result_valid=0, disp_value tracks switches[9:6] next cycle.
- Hold enter_btn high for 100 cycles in GET_A -> exactly one transition, to GET_B (stage=010).
- In GET_B, assert enter_btn and clear_btn on the same cycle -> state GET_A, alu_a=0, alu_b=0, disp_value=0.
- Sim with BLINK_DIV=8: in GET_A, disp_blank toggles every 8 cycles. After the op ENTER, disp_blank=0 through EXEC and SHOW.
- Drop rst_n asynchronously mid-EXEC (SETTLE_CYCLES=16, after 5 cycles) -> all outputs at reset values immediately, stage=001, result_valid never asserted.
